spi_master16: RTL and testbench
===============================

SPI_MASTER16 -- requirements
Module: spi_master16

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCK half-period; legal values 4..255.
REQ-002 The block SHALL have parameter GUARD, default 2, meaning clk cycles of SSEL setup, hold and minimum deselect; legal values 1..255.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request one 16-bit transfer; sampled only in IDLE.
REQ-006 The block SHALL have port tx_data  input  16  word to send MSB first; captured when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while a transfer is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse when rx_data is updated.
REQ-009 The block SHALL have port rx_data  output  16  last word received from MISO.
REQ-010 The block SHALL have port SCK  output  1  SPI clock; idles low.
REQ-011 The block SHALL have port MOSI  output  1  serial data to the slave.
REQ-012 The block SHALL have port MISO  input  1  serial data from the slave; asynchronous to clk.
REQ-013 The block SHALL have port SSEL  output  1  active-low slave select.

Function
REQ-014 The block SHALL implement SPI mode 0, 16-bit words, MSB first: slave samples MOSI on SCK rising; both ends shift on SCK falling.
REQ-015 The block SHALL implement states IDLE, SETUP, XFER, HOLD and GAP.
REQ-016 In IDLE with start=1 at an edge, the block SHALL capture tx_data and enter SETUP; SSEL=0, busy=1 and MOSI=tx_data[15] from the next cycle.
REQ-017 SETUP SHALL last GUARD cycles, with SCK=0, then enter XFER.
REQ-018 XFER SHALL produce 16 SCK periods, each CLK_DIV cycles low followed by CLK_DIV cycles high, for 32*CLK_DIV cycles in total.
REQ-019 MOSI SHALL change only on the cycle SCK falls, and SHALL NOT change after the 16th falling edge; bit n (15 down to 0) SHALL be stable across the nth rising edge.
REQ-020 MISO SHALL pass through a 2-flop synchronizer.
REQ-021 On the last clk cycle of each SCK high phase, the block SHALL shift the synchronized MISO into an internal shift register, MSB first.
REQ-022 After the 16th high phase, SCK SHALL return to 0 and the block SHALL enter HOLD for GUARD cycles with SSEL=0.
REQ-023 On HOLD exit, the block SHALL take SSEL=1 and enter GAP; in that same first GAP cycle, rx_data SHALL take the received word and done SHALL be 1 for exactly one cycle.
REQ-024 GAP SHALL last GUARD cycles with SSEL=1, then return to IDLE with busy=0.
REQ-025 busy SHALL be high for exactly 3*GUARD + 32*CLK_DIV cycles per transfer.
REQ-026 start SHALL be ignored whenever busy=1; no queuing.
REQ-027 With start held high, a new transfer SHALL be accepted on the first IDLE cycle, so SSEL is high for at least GUARD+1 cycles between words.
REQ-028 Changes on tx_data after acceptance SHALL NOT affect the word in flight.
REQ-029 rx_data SHALL hold its value between done pulses.
REQ-030 All outputs SHALL be registered.
REQ-031 The bit counter SHALL be 5 bits and SHALL NOT wrap within a transfer.

Reset
REQ-032 While rst_n=0, regardless of state, the block SHALL force: state=IDLE, SCK=0, SSEL=1, MOSI=0, busy=0, done=0, rx_data=16'h0000, shift registers and counters 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done pulse.
REQ-034 After rst_n deasserts, the first start SHALL be honoured on the following clock edge.

Verification
REQ-035 Loopback (MISO=MOSI), CLK_DIV=4, GUARD=2, tx_data=16'hA5C3, start pulse -> 16 SCK rising edges, SSEL low 134-2=132 cycles, busy high 134 cycles, one done pulse, rx_data=16'hA5C3.
REQ-036 MISO tied 1, tx_data=16'h0000 -> MOSI stays 0, rx_data=16'hFFFF; then MISO tied 0 -> rx_data=16'h0000.
REQ-037 Slave model latching MOSI on each SCK rise, tx_data=16'h8001 -> model receives 16'h8001; MOSI never toggles while SCK=1.
REQ-038 start pulsed again 10 cycles after acceptance, with tx_data changed to 16'h1234 -> ignored; exactly one transfer, with the original data.
REQ-039 start held high for two transfers -> SSEL high for ≥3 cycles between words, two done pulses, both words correct.
REQ-040 rst_n low at the 7th SCK rise -> the same cycle gives SSEL=1, SCK=0, busy=0, rx_data=0, and no done; a fresh transfer after release completes correctly.

Source files
------------

// File: rtl/spi_master16.sv
// SPI mode-0 master moving one 16-bit word per transfer, MSB first, with guarded slave select.
// Latency: busy for 3*GUARD + 32*CLK_DIV cycles; done pulses in the first cycle after SSEL rises.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
module spi_master16 #(
  parameter int CLK_DIV = 4,
  parameter int GUARD   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SSEL
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [7:0] GUARD_LAST = 8'(GUARD - 1);
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  tmr;       // cycles spent in the current guard phase or SCK half-period
  logic [4:0]  bit_cnt;   // completed SCK periods; stops at 16
  logic [14:0] tx_sh;     // bits still to be sent after the one currently on MOSI
  logic [15:0] rx_sh;
  logic        miso_s1, miso_s2;
  logic        guard_end, half_end;
  logic        busy_nxt, ssel_nxt;

  assign guard_end = (tmr == GUARD_LAST);
  assign half_end  = (tmr == DIV_LAST);

  // Next state plus the registered-output values that depend on it
  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    ssel_nxt  = 1'b1;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (guard_end) state_nxt = XFER;
      XFER:    if (half_end && SCK && bit_cnt == 5'd15) state_nxt = HOLD;
      HOLD:    if (guard_end) state_nxt = GAP;
      GAP:     if (guard_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    ssel_nxt = !(state_nxt == SETUP || state_nxt == XFER || state_nxt == HOLD);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Timers, shift registers, MISO synchronizer and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
      SSEL    <= 1'b1;
    end else begin
      miso_s1 <= MISO;
      miso_s2 <= miso_s1;
      busy    <= busy_nxt;
      SSEL    <= ssel_nxt;
      done    <= (state == HOLD) && (state_nxt == GAP);
      if (state == HOLD && state_nxt == GAP) rx_data <= rx_sh;

      // Timer restarts on every state change and every SCK half-period
      if (state_nxt != state)          tmr <= '0;
      else if (state == XFER && half_end) tmr <= '0;
      else if (state != IDLE)          tmr <= tmr + 8'd1;

      if (state == IDLE && state_nxt == SETUP) begin
        tx_sh   <= tx_data[14:0];
        MOSI    <= tx_data[15];
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (state == XFER && half_end) begin
        if (!SCK) begin
          SCK <= 1'b1;
        end else begin
          // End of high phase: sample the slave, drop SCK, present the next bit
          SCK     <= 1'b0;
          rx_sh   <= {rx_sh[14:0], miso_s2};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt != 5'd15) begin
            MOSI  <= tx_sh[14];
            tx_sh <= {tx_sh[13:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master16.sv
// Directed bench for spi_master16 at CLK_DIV=4, GUARD=2.
// Expected values are hand-derived constants; monitors count cycles and edges on the falling clk edge.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
module tb_spi_master16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        busy, done, sck, mosi, ssel;
  logic [15:0] rx_data;
  logic        miso;
  logic        loop = 1'b0;
  logic        miso_val = 1'b0;

  assign miso = loop ? mosi : miso_val;

  always #5 clk = ~clk;

  spi_master16 #(.CLK_DIV(4), .GUARD(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .SCK     (sck),
    .MOSI    (mosi),
    .MISO    (miso),
    .SSEL    (ssel)
  );

  int tests = 0;
  int failed = 0;

  // Free-running monitors
  int busy_cnt = 0, ssel_lo_cnt = 0, done_cnt = 0, rise_cnt = 0;
  int mosi_hi_chg = 0, mosi_one_cnt = 0;
  logic sck_prev = 1'b0, mosi_prev = 1'b0;
  logic [15:0] slave_sh = 16'h0000;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!ssel) ssel_lo_cnt++;
    if (done) done_cnt++;
    if (sck && !sck_prev) rise_cnt++;
    if (sck && (mosi != mosi_prev)) mosi_hi_chg++;
    if (busy && mosi) mosi_one_cnt++;
    sck_prev  = sck;
    mosi_prev = mosi;
  end

  // Slave model: latches MOSI on each SCK rise
  always @(posedge sck) slave_sh <= {slave_sh[14:0], mosi};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] data);
    tx_data = data;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int b0, s0, d0, r0, h0, o0, g, n, rises;
    logic prev;

    // Reset values while rst_n is held low
    repeat (3) tick();
    check("rst sck",  {31'b0, sck},  32'd0);
    check("rst ssel", {31'b0, ssel}, 32'd1);
    check("rst mosi", {31'b0, mosi}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst rx",   {16'b0, rx_data}, 32'h0000);
    rst_n = 1'b1;
    tick();

    // Loopback A5C3
    loop = 1'b1;
    b0 = busy_cnt; s0 = ssel_lo_cnt; d0 = done_cnt; r0 = rise_cnt; h0 = mosi_hi_chg;
    do_start(16'hA5C3);
    check("t1 ssel first", {31'b0, ssel}, 32'd0);
    check("t1 busy first", {31'b0, busy}, 32'd1);
    check("t1 mosi first", {31'b0, mosi}, 32'd1);
    wait_busy_low("t1 end");
    repeat (3) tick();
    check("t1 sck rises", rise_cnt - r0,    32'd16);
    check("t1 ssel low",  ssel_lo_cnt - s0, 32'd132);
    check("t1 busy len",  busy_cnt - b0,    32'd134);
    check("t1 done cnt",  done_cnt - d0,    32'd1);
    check("t1 rx",        {16'b0, rx_data}, 32'hA5C3);
    check("t1 mosi hi",   mosi_hi_chg - h0, 32'd0);

    // MISO tied high, sending zeros; then MISO tied low
    loop = 1'b0;
    miso_val = 1'b1;
    o0 = mosi_one_cnt;
    do_start(16'h0000);
    wait_busy_low("t2a end");
    tick();
    check("t2a mosi ones", mosi_one_cnt - o0, 32'd0);
    check("t2a rx",        {16'b0, rx_data},  32'hFFFF);
    miso_val = 1'b0;
    do_start(16'h0000);
    wait_busy_low("t2b end");
    tick();
    check("t2b rx", {16'b0, rx_data}, 32'h0000);

    // Slave model receives 8001
    h0 = mosi_hi_chg;
    do_start(16'h8001);
    wait_busy_low("t3 end");
    tick();
    check("t3 slave",   {16'b0, slave_sh}, 32'h8001);
    check("t3 mosi hi", mosi_hi_chg - h0,  32'd0);

    // Second start while busy is ignored; tx_data change does not disturb word in flight
    loop = 1'b1;
    b0 = busy_cnt; d0 = done_cnt;
    do_start(16'h5A3C);
    repeat (9) tick();
    tx_data = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy_low("t4 end");
    repeat (5) tick();
    check("t4 done cnt", done_cnt - d0,    32'd1);
    check("t4 busy len", busy_cnt - b0,    32'd134);
    check("t4 rx",       {16'b0, rx_data}, 32'h5A3C);
    check("t4 idle",     {31'b0, busy},    32'd0);

    // start held for two back-to-back words
    d0 = done_cnt;
    tx_data = 16'h3C96;
    start = 1'b1;
    wait_done("t5 done1");
    check("t5 rx1", {16'b0, rx_data}, 32'h3C96);
    tx_data = 16'hC369;
    g = 0;
    while (ssel && g < 50) begin
      g++;
      tick();
    end
    check("t5 ssel gap", g, 32'd3);
    wait_done("t5 done2");
    start = 1'b0;
    check("t5 rx2", {16'b0, rx_data}, 32'hC369);
    wait_busy_low("t5 end");
    repeat (4) tick();
    check("t5 done cnt", done_cnt - d0, 32'd2);

    // Reset at the 7th SCK rise aborts the transfer
    d0 = done_cnt;
    do_start(16'hFFFF);
    rises = 0;
    n = 0;
    while (rises < 7 && n < 500) begin
      prev = sck;
      tick();
      n++;
      if (sck && !prev) rises++;
    end
    check("t6 rises", rises, 32'd7);
    rst_n = 1'b0;
    #1;
    check("t6 sck",  {31'b0, sck},  32'd0);
    check("t6 ssel", {31'b0, ssel}, 32'd1);
    check("t6 busy", {31'b0, busy}, 32'd0);
    check("t6 rx",   {16'b0, rx_data}, 32'h0000);
    check("t6 done", {31'b0, done}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    do_start(16'h6B2D);
    check("t6 start after rst", {31'b0, busy}, 32'd1);
    check("t6 no abort done",   done_cnt - d0, 32'd0);
    wait_busy_low("t6 end");
    tick();
    check("t6 rx fresh",  {16'b0, rx_data}, 32'h6B2D);
    check("t6 done cnt",  done_cnt - d0,    32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
